neokeon_rotl_sequencer: RTL and testbench



---
 rtl/neokeon_pkg.sv | 18 +
 rtl/neokeon_rotl_sequencer_rotl1.sv | 11 +
 rtl/neokeon_rotl_sequencer.sv | 147 ++++++++++++++
 tb/tb_neokeon_rotl_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neokeon_pkg.sv
// Shared constants and FSM state type for the Neokeon rotation sequencer.
package neokeon_pkg;

  localparam int NK_WORD_W    = 32;
  localparam int NK_WORDS     = 4;
  localparam int NK_AMT_W     = 5;
  localparam int NK_BYTE_STEP = 8;

  typedef enum logic [1:0] {
    NK_IDLE,
    NK_ROT,
    NK_DONE
  } nk_state_e;

  typedef logic [NK_WORD_W-1:0] nk_word_t;
  typedef logic [NK_AMT_W-1:0]  nk_amt_t;

endpackage

// File: rtl/neokeon_rotl_sequencer_rotl1.sv
// Shared single-bit rotate-left unit: the one rotation datapath of the round.
module NeokeonROTL32by1fun
  import neokeon_pkg::*;
(
  input  logic [NK_WORD_W-1:0] in_word,
  output logic [NK_WORD_W-1:0] out_word
);

  assign out_word = {in_word[NK_WORD_W-2:0], in_word[NK_WORD_W-1]};

endmodule

// File: rtl/neokeon_rotl_sequencer.sv
// Multi-cycle word rotation sequencer built around one shared rotate-by-1 unit.
// Optional build macro NEOKEON_ROTL_BYTESTEP_EN adds a byte-rotate step for rem >= 8.
module neokeon_rotl_sequencer
  import neokeon_pkg::*;
(
  input  logic                          inClk,
  input  logic                          inRst,
  input  logic                          inValid,
  output logic                          outReady,
  input  logic [NK_WORDS*NK_WORD_W-1:0] inState,
  input  logic [NK_WORDS*NK_AMT_W-1:0]  inAmounts,
  output logic                          outValid,
  input  logic                          inReady,
  output logic [NK_WORDS*NK_WORD_W-1:0] outState,
  output logic                          outBusy
);

  nk_state_e state_q, state_d;
  nk_word_t  word_q [NK_WORDS];
  nk_word_t  word_d [NK_WORDS];
  nk_amt_t   rem_q  [NK_WORDS];
  nk_amt_t   rem_d  [NK_WORDS];
  logic      ready_q, ready_d;
  logic      valid_q, valid_d;
  logic      busy_q, busy_d;

  logic [1:0] sel;
  logic       any_rem;
  logic       rem_left;
  nk_word_t   sel_word;
  nk_word_t   rot1_word;

  // Lowest index with work remaining wins; zero-amount words are never visited.
  always_comb begin
    sel     = '0;
    any_rem = 1'b0;
    for (int i = NK_WORDS - 1; i >= 0; i--) begin
      if (rem_q[i] != '0) begin
        sel     = 2'(i);
        any_rem = 1'b1;
      end
    end
    sel_word = word_q[sel];
  end

  NeokeonROTL32by1fun u_rotl1 (
    .in_word  (sel_word),
    .out_word (rot1_word)
  );

`ifdef NEOKEON_ROTL_BYTESTEP_EN
  nk_word_t byte_word;
  assign byte_word = {sel_word[NK_WORD_W-NK_BYTE_STEP-1:0],
                      sel_word[NK_WORD_W-1:NK_WORD_W-NK_BYTE_STEP]};
`endif

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    rem_d    = rem_q;
    rem_left = 1'b0;

    unique case (state_q)
      NK_IDLE: begin
        if (ready_q && inValid) begin
          for (int i = 0; i < NK_WORDS; i++) begin
            word_d[i] = inState[NK_WORD_W*i +: NK_WORD_W];
            rem_d[i]  = inAmounts[NK_AMT_W*i +: NK_AMT_W];
          end
          state_d = (inAmounts != '0) ? NK_ROT : NK_DONE;
        end
      end

      NK_ROT: begin
        if (any_rem) begin
`ifdef NEOKEON_ROTL_BYTESTEP_EN
          if (rem_q[sel] >= NK_AMT_W'(NK_BYTE_STEP)) begin
            word_d[sel] = byte_word;
            rem_d[sel]  = rem_q[sel] - NK_AMT_W'(NK_BYTE_STEP);
          end else begin
            word_d[sel] = rot1_word;
            rem_d[sel]  = rem_q[sel] - NK_AMT_W'(1);
          end
`else
          word_d[sel] = rot1_word;
          rem_d[sel]  = rem_q[sel] - NK_AMT_W'(1);
`endif
        end
        for (int i = 0; i < NK_WORDS; i++) begin
          if (rem_d[i] != '0) begin
            rem_left = 1'b1;
          end
        end
        if (!rem_left) begin
          state_d = NK_DONE;
        end
      end

      NK_DONE: begin
        if (inReady) begin
          state_d = NK_IDLE;
        end
      end

      default: state_d = NK_IDLE;
    endcase

    ready_d = (state_d == NK_IDLE);
    valid_d = (state_d == NK_DONE);
    busy_d  = (state_d != NK_IDLE);
  end

  // Handshake flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= NK_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NK_WORDS; i++) begin
        word_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NK_WORDS; i++) begin
        word_q[i] <= word_d[i];
        rem_q[i]  <= rem_d[i];
      end
    end
  end

  always_comb begin
    outState = '0;
    for (int i = 0; i < NK_WORDS; i++) begin
      outState[NK_WORD_W*i +: NK_WORD_W] = word_q[i];
    end
  end

  assign outReady = ready_q;
  assign outValid = valid_q;
  assign outBusy  = busy_q;

endmodule

// File: tb/tb_neokeon_rotl_sequencer.sv
// Scoreboard bench for neokeon_rotl_sequencer: stimulus pushes expected results, a monitor checks them.
module tb_neokeon_rotl_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic [19:0]  in_amounts;
  logic         out_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_busy;

  typedef struct {
    logic [127:0] st;
    int           edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   seen     = 0;

`ifdef NEOKEON_ROTL_BYTESTEP_EN
  localparam int S_BYTE_TEST = 11;
`else
  localparam int S_BYTE_TEST = 39;
`endif

  neokeon_rotl_sequencer dut (
    .inClk     (clk),
    .inRst     (rst),
    .inValid   (in_valid),
    .outReady  (out_ready),
    .inState   (in_state),
    .inAmounts (in_amounts),
    .outValid  (out_valid),
    .inReady   (in_ready),
    .outState  (out_state),
    .outBusy   (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_words(input logic [31:0] w3, input logic [31:0] w2,
                                               input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [19:0] pack_amts(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Monitor: every rising of outValid consumes one scoreboard entry (data and latency).
  initial forever begin
    @(negedge clk);
    if (rst) begin
      seen = 0;
    end else if (out_valid && !seen) begin
      seen = 1;
      if (sb.size() == 0) begin
        check_int("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_vec("result_state", out_state, e.st);
        check_int("result_latency", cyc, e.edge_no);
      end
    end else if (!out_valid) begin
      seen = 0;
    end
  end

  // Waits for outReady, issues one request and records the expected result and edge.
  task automatic apply_stimulus(input logic [127:0] st, input logic [19:0] amt,
                                input logic [127:0] exp, input int s);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!out_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready) begin
      check_int("ready_timeout", 0, 1);
      return;
    end
    in_state   = st;
    in_amounts = amt;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    e.st      = exp;
    e.edge_no = cyc + s;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_int("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial #300000 begin
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pi1_in, pi1_exp, z_st, bp_exp;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_ready   = 1'b1;
    in_state   = '0;
    in_amounts = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_ready", int'(out_ready), 0);
    check_int("rst_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(out_busy), 0);
    check_vec("rst_state", out_state, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_int("idle_ready", int'(out_ready), 1);

    // Single word, one step
    apply_stimulus(pack_words(0, 0, 0, 32'h1111aaaa), pack_amts(0, 0, 0, 1),
                   pack_words(0, 0, 0, 32'h22235554), 1);
    wait_drain();

    // Pi1 rotation pattern, S=8 in both builds
    pi1_in  = pack_words(32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001);
    pi1_exp = pack_words(32'h00000006, 32'h00000030, 32'h00000003, 32'h80000001);
    apply_stimulus(pi1_in, pack_amts(2, 5, 1, 0), pi1_exp, 8);
    wait_drain();

    // Byte-sized and rotate-right-by-1 amounts
    apply_stimulus(pack_words(0, 0, 32'h00000001, 32'h12345678), pack_amts(0, 0, 31, 8),
                   pack_words(0, 0, 32'h80000000, 32'h34567812), S_BYTE_TEST);
    wait_drain();

    // All-zero amounts: result right after accept, busy for one cycle
    z_st = pack_words(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d);
    apply_stimulus(z_st, '0, z_st, 0);
    @(negedge clk);
    check_int("zero_busy_high", int'(out_busy), 1);
    @(negedge clk);
    check_int("zero_busy_low", int'(out_busy), 0);
    wait_drain();

    // Backpressure: DONE holds, extra request ignored
    in_ready = 1'b0;
    bp_exp   = pack_words(0, 32'h00000008, 0, 0);
    apply_stimulus(pack_words(0, 32'h00000001, 0, 0), pack_amts(0, 3, 0, 0), bp_exp, 3);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      in_state   = pack_words(32'hffffffff, 32'h0f0f0f0f, 32'h12121212, 32'h55555555);
      in_amounts = pack_amts(1, 1, 1, 1);
      in_valid   = 1'b1;
      @(negedge clk);
      check_vec("bp_state_hold", out_state, bp_exp);
      check_int("bp_ready_low", int'(out_ready), 0);
      check_int("bp_valid_hold", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(negedge clk);
    check_int("bp_release_valid", int'(out_valid), 0);
    check_int("bp_release_ready", int'(out_ready), 1);
    repeat (3) @(negedge clk);
    check_int("bp_no_accept_busy", int'(out_busy), 0);
    check_int("bp_no_accept_valid", int'(out_valid), 0);

    // Reset three cycles into an S=8 job
    @(negedge clk);
    in_state   = pi1_in;
    in_amounts = pack_amts(2, 5, 1, 0);
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("mid_busy_before", int'(out_busy), 1);
    rst = 1'b1;
    #1;
    check_int("mid_rst_valid", int'(out_valid), 0);
    check_int("mid_rst_busy", int'(out_busy), 0);
    check_vec("mid_rst_state", out_state, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_int("mid_rst_ready", int'(out_ready), 1);
    apply_stimulus(pi1_in, pack_amts(2, 5, 1, 0), pi1_exp, 8);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
